// File: rtl/modexp_ctrl_if.sv
// Handshake bus between the modexp sequencer and the Montgomery multiplier core.
// The controller is the master and the core is the slave.
interface modexp_ctrl_if #(
  parameter int WIDTH = 1024
);
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_m;
  logic [WIDTH-1:0] mm_result;
  logic             mm_done;

  modport master (
    output mm_start,
    output mm_a,
    output mm_b,
    output mm_m,
    input  mm_result,
    input  mm_done
  );

  modport slave (
    input  mm_start,
    input  mm_a,
    input  mm_b,
    input  mm_m,
    output mm_result,
    output mm_done
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M on one
// external Montgomery multiplier, with conversion into and out of Montgomery form.
module modexp_ctrl #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int LEN_W     = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]     in_exp_len,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r_mod_m,
  input  logic [WIDTH-1:0]     in_r2_mod_m,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  modexp_ctrl_if.master        mm
);

  localparam int               IDX_W       = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [LEN_W-1:0] EXP_LEN_MAX = LEN_W'(EXP_WIDTH);
  localparam logic [WIDTH-1:0] PLAIN_ONE   = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOMONT,
    S_SQR,
    S_MUL,
    S_FROMMONT,
    S_FIN
  } state_t;

  state_t               state_reg, state_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [WIDTH-1:0]     result_reg, result_next;
  logic                 mm_start_reg, mm_start_next;
  logic [WIDTH-1:0]     mm_a_reg, mm_a_next;
  logic [WIDTH-1:0]     mm_b_reg, mm_b_next;
  logic [WIDTH-1:0]     mm_m_reg, mm_m_next;
  logic [EXP_WIDTH-1:0] e_reg, e_next;
  logic [WIDTH-1:0]     rm_reg, rm_next;
  logic [WIDTH-1:0]     xm_reg, xm_next;
  logic [LEN_W-1:0]     len_reg, len_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 mm_accept;

  // A done seen while our own start pulse is still on the bus belongs to nobody.
  assign mm_accept = mm.mm_done && !mm_start_reg;

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign result      = result_reg;
  assign mm.mm_start = mm_start_reg;
  assign mm.mm_a     = mm_a_reg;
  assign mm.mm_b     = mm_b_reg;
  assign mm.mm_m     = mm_m_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      mm_start_reg <= 1'b0;
      mm_a_reg     <= '0;
      mm_b_reg     <= '0;
      mm_m_reg     <= '0;
      e_reg        <= '0;
      rm_reg       <= '0;
      xm_reg       <= '0;
      len_reg      <= '0;
      idx_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      mm_start_reg <= mm_start_next;
      mm_a_reg     <= mm_a_next;
      mm_b_reg     <= mm_b_next;
      mm_m_reg     <= mm_m_next;
      e_reg        <= e_next;
      rm_reg       <= rm_next;
      xm_reg       <= xm_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
    end
  end

  // The running accumulator lives in mm_a: every op is issued on the same
  // edge that accepts the previous result, so it is fed straight from mm_result.
  always_comb begin
    state_next    = state_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    result_next   = result_reg;
    mm_start_next = 1'b0;
    mm_a_next     = mm_a_reg;
    mm_b_next     = mm_b_reg;
    mm_m_next     = mm_m_reg;
    e_next        = e_reg;
    rm_next       = rm_reg;
    xm_next       = xm_reg;
    len_next      = len_reg;
    idx_next      = idx_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_TOMONT;
          busy_next     = 1'b1;
          mm_start_next = 1'b1;
          mm_a_next     = in_x;
          mm_b_next     = in_r2_mod_m;
          mm_m_next     = in_m;
          e_next        = in_e;
          rm_next       = in_r_mod_m;
          len_next      = (in_exp_len > EXP_LEN_MAX) ? EXP_LEN_MAX : in_exp_len;
        end
      end

      S_TOMONT: begin
        if (mm_accept) begin
          xm_next       = mm.mm_result;
          idx_next      = IDX_W'(len_reg - 1'b1);
          mm_start_next = 1'b1;
          mm_a_next     = rm_reg;
          if (len_reg == '0) begin
            state_next = S_FROMMONT;
            mm_b_next  = PLAIN_ONE;
          end else begin
            state_next = S_SQR;
            mm_b_next  = rm_reg;
          end
        end
      end

      S_SQR: begin
        if (mm_accept) begin
          mm_start_next = 1'b1;
          mm_a_next     = mm.mm_result;
          if (e_reg[idx_reg]) begin
            state_next = S_MUL;
            mm_b_next  = xm_reg;
          end else if (idx_reg == '0) begin
            state_next = S_FROMMONT;
            mm_b_next  = PLAIN_ONE;
          end else begin
            idx_next  = idx_reg - 1'b1;
            mm_b_next = mm.mm_result;
          end
        end
      end

      S_MUL: begin
        if (mm_accept) begin
          mm_start_next = 1'b1;
          mm_a_next     = mm.mm_result;
          if (idx_reg == '0) begin
            state_next = S_FROMMONT;
            mm_b_next  = PLAIN_ONE;
          end else begin
            state_next = S_SQR;
            idx_next   = idx_reg - 1'b1;
            mm_b_next  = mm.mm_result;
          end
        end
      end

      S_FROMMONT: begin
        if (mm_accept) begin
          state_next  = S_FIN;
          result_next = mm.mm_result;
          done_next   = 1'b1;
          busy_next   = 1'b0;
        end
      end

      S_FIN: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
